// File: rtl/aes128_decrypt_iter_pkg.sv
// Shared AES-128 tables and GF(2^8) helpers. The same package serves the encryptor's
// SubBytes and key-expansion logic.
package aes128_decrypt_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] RND_FIRST = 4'd1;
    localparam logic [3:0] RND_LAST  = 4'd10;

    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Entry 0 and 11..15 are never used; they pad the table to the 4-bit round index.
    localparam logic [0:15][7:0] RCON_TABLE = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TABLE[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        return RCON_TABLE[rnd];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes128_decrypt_iter_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// except on the final round, InvMixColumns.
module aes_inv_round
    import aes128_decrypt_iter_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [7:0] w_t  [16];
    logic [7:0] w_mc [16];

    // Byte index r + 4*c is row r, column c; InvShiftRows pulls row r from column c - r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = r + 4 * ((c - r + 4) % 4);
            localparam int DST = r + 4 * c;
            assign w_t[DST] = inv_sbox(i_state[127-8*SRC -: 8]) ^ i_round_key[127-8*DST -: 8];
        end

        assign w_mc[4*c+0] = gmul(w_t[4*c+0], 8'h0e) ^ gmul(w_t[4*c+1], 8'h0b)
                           ^ gmul(w_t[4*c+2], 8'h0d) ^ gmul(w_t[4*c+3], 8'h09);
        assign w_mc[4*c+1] = gmul(w_t[4*c+0], 8'h09) ^ gmul(w_t[4*c+1], 8'h0e)
                           ^ gmul(w_t[4*c+2], 8'h0b) ^ gmul(w_t[4*c+3], 8'h0d);
        assign w_mc[4*c+2] = gmul(w_t[4*c+0], 8'h0d) ^ gmul(w_t[4*c+1], 8'h09)
                           ^ gmul(w_t[4*c+2], 8'h0e) ^ gmul(w_t[4*c+3], 8'h0b);
        assign w_mc[4*c+3] = gmul(w_t[4*c+0], 8'h0b) ^ gmul(w_t[4*c+1], 8'h0d)
                           ^ gmul(w_t[4*c+2], 8'h09) ^ gmul(w_t[4*c+3], 8'h0e);
    end

    for (genvar i = 0; i < 16; i++) begin : g_out
        assign o_state[127-8*i -: 8] = i_last ? w_t[i] : w_mc[i];
    end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key forward to round key 10, then runs one
// inverse round per clock while walking the key schedule backwards.
module aes128_decrypt_iter
    import aes128_decrypt_iter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    function automatic logic [127:0] forward_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undoes forward_next: recovers the previous round key from the current one.
    function automatic logic [127:0] inverse_prev(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    state_t       r_fsm;
    logic [127:0] r_ct;
    logic [127:0] r_key;
    logic [127:0] r_state;
    logic [127:0] r_out_data;
    logic [3:0]   r_rnd;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic [7:0]   w_rcon;
    logic [127:0] w_key_fwd;
    logic [127:0] w_key_prev;
    logic [127:0] w_round_out;

    assign w_rcon     = rcon(r_rnd);
    assign w_key_fwd  = forward_next(r_key, w_rcon);
    assign w_key_prev = inverse_prev(r_key, w_rcon);

    aes_inv_round u_inv_round (
        .i_state     (r_state),
        .i_round_key (w_key_prev),
        .i_last      (r_rnd == RND_FIRST),
        .o_state     (w_round_out)
    );

    // NOTE: all state here is updated with <= so every register samples pre-edge values;
    // blocking = in a clocked block would let later statements see half-updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= ST_IDLE;
            r_ct        <= '0;
            r_key       <= '0;
            r_state     <= '0;
            r_out_data  <= '0;
            r_rnd       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_ct       <= in_data;
                        r_key      <= in_key;
                        r_rnd      <= RND_FIRST;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_fsm      <= ST_KEYEXP;
                    end
                end
                ST_KEYEXP: begin
                    r_key <= w_key_fwd;
                    if (r_rnd == RND_LAST) begin
                        r_state <= r_ct ^ w_key_fwd;
                        r_fsm   <= ST_ROUND;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                ST_ROUND: begin
                    if (r_rnd > RND_FIRST) begin
                        r_state <= w_round_out;
                        r_key   <= w_key_prev;
                        r_rnd   <= r_rnd - 4'd1;
                    end else begin
                        r_out_data  <= w_round_out;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_fsm       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= ST_IDLE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

endmodule
